// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared types, colour constants and status decode for rgb_status_seq
package rgb_pkg;

    localparam int COLOR_W = 3;
    localparam logic [COLOR_W-1:0] COLOR_MAX = 3'd7;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_NORMAL = 2'd1,
        ST_WARN   = 2'd2,
        ST_ALARM  = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_NORMAL = 2'd1,
        S_WARN   = 2'd2,
        S_ALARM  = 2'd3
    } state_e;

    // Each status code selects exactly one display state.
    function automatic state_e status_to_state(input status_e s);
        case (s)
            ST_OFF:    return S_OFF;
            ST_NORMAL: return S_NORMAL;
            ST_WARN:   return S_WARN;
            default:   return S_ALARM;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - animation prescaler emitting a one-cycle tick every TICK_DIV clocks
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the count from 0 (animation restart)
//   tick     : high for one cycle when the count is TICK_DIV-1
module tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/rgb_status_seq.sv
// rtl/rgb_status_seq.sv - maps health status onto animated RGB levels for the PWM stage
//   clk, rst         : clock, synchronous active-high reset
//   status_valid     : strobe, status sampled when high
//   status           : 0=off 1=normal 2=warn 3=alarm
//   alarm_ack        : releases the sticky alarm
//   color_r/g/b      : registered 3-bit levels to the PWM stage
//   alarm_active     : high while the alarm state is held
module rgb_status_seq
    import rgb_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000,
    parameter int BLINK_STEPS = 8,
    parameter logic [COLOR_W-1:0] NORMAL_LEVEL = 3'd4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               status_valid,
    input  logic [1:0]         status,
    input  logic               alarm_ack,
    output logic [COLOR_W-1:0] color_r,
    output logic [COLOR_W-1:0] color_g,
    output logic [COLOR_W-1:0] color_b,
    output logic               alarm_active
);

    localparam int BW = (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_STEPS - 1);

    state_e             state;
    state_e             base_state;
    state_e             next_state;
    logic               ack_hit;
    logic               restart;
    logic               tick;
    logic [COLOR_W-1:0] level;
    logic               dir_down;
    logic [BW-1:0]      blink_cnt;
    logic               phase;

    // The ack is applied before the status request, so ack + status 3 is
    // evaluated against S_OFF and restarts the alarm from its dark phase.
    always_comb begin
        ack_hit    = alarm_ack && (state == S_ALARM);
        base_state = ack_hit ? S_OFF : state;
        next_state = base_state;
        if (status_valid && (base_state != S_ALARM)) begin
            next_state = status_to_state(status_e'(status));
        end
        restart = ack_hit || (next_state != base_state);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_OFF;
            alarm_active <= 1'b0;
        end else begin
            state        <= next_state;
            alarm_active <= (next_state == S_ALARM);
        end
    end

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (restart),
        .tick (tick)
    );

    // Animation state; a restart wins over a coincident tick.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            level     <= '0;
            dir_down  <= 1'b0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (tick) begin
            case (state)
                S_WARN: begin
                    if (!dir_down) begin
                        if (level != COLOR_MAX) level <= level + COLOR_W'(1);
                        if (level == COLOR_MAX - COLOR_W'(1)) dir_down <= 1'b1;
                    end else begin
                        if (level != '0) level <= level - COLOR_W'(1);
                        if (level == COLOR_W'(1)) dir_down <= 1'b0;
                    end
                end
                S_ALARM: begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt <= '0;
                        phase     <= ~phase;
                    end else begin
                        blink_cnt <= blink_cnt + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Colours follow the state register one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            color_r <= '0;
            color_g <= '0;
            color_b <= '0;
        end else begin
            color_r <= '0;
            color_g <= '0;
            color_b <= '0;
            case (state)
                S_NORMAL: color_g <= NORMAL_LEVEL;
                S_WARN: begin
                    color_r <= level;
                    color_g <= level >> 1;
                end
                S_ALARM: color_r <= phase ? COLOR_MAX : '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_status_seq.sv
// tb/tb_rgb_status_seq.sv - directed self-checking bench for rgb_status_seq
module tb_rgb_status_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       status_valid = 1'b0;
    logic [1:0] status = 2'd0;
    logic       alarm_ack = 1'b0;
    logic [2:0] color_r, color_g, color_b;
    logic       alarm_active;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rgb_status_seq #(
        .TICK_DIV     (4),
        .BLINK_STEPS  (2),
        .NORMAL_LEVEL (3'd4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .status_valid (status_valid),
        .status       (status),
        .alarm_ack    (alarm_ack),
        .color_r      (color_r),
        .color_g      (color_g),
        .color_b      (color_b),
        .alarm_active (alarm_active)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ex(input int a, input int r, input int g, input int b);
        logic [31:0] v;
        v = '0;
        v[9]   = a[0];
        v[8:6] = r[2:0];
        v[5:3] = g[2:0];
        v[2:0] = b[2:0];
        return v;
    endfunction

    function automatic logic [31:0] outs();
        return {22'd0, alarm_active, color_r, color_g, color_b};
    endfunction

    // Breathing level after i ticks: triangle 0..7..0, period 14.
    function automatic int tri_lvl(input int i);
        int p;
        p = i % 14;
        return (p <= 7) ? p : 14 - p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic edge_in(input logic v, input logic [1:0] s, input logic a);
        status_valid = v;
        status       = s;
        alarm_ack    = a;
        step();
        status_valid = 1'b0;
        status       = 2'd0;
        alarm_ack    = 1'b0;
    endtask

    initial begin
        int lv;

        // 1. reset
        repeat (3) step();
        check("reset_outs", outs(), ex(0, 0, 0, 0));
        rst = 1'b0;
        step();
        check("off_after_reset", outs(), ex(0, 0, 0, 0));

        // 2. normal
        edge_in(1'b1, 2'd1, 1'b0);
        check("normal_latency", outs(), ex(0, 0, 0, 0));
        step();
        check("normal_g", outs(), ex(0, 0, 4, 0));
        step();
        step();
        check("normal_hold", outs(), ex(0, 0, 4, 0));

        // 3. warn breathing, with a same-state request mid-ramp
        edge_in(1'b1, 2'd2, 1'b0);
        check("warn_latency", outs(), ex(0, 0, 4, 0));
        for (int m = 1; m <= 60; m++) begin
            if (m == 22) edge_in(1'b1, 2'd2, 1'b0);
            else step();
            lv = tri_lvl((m - 1) / 4);
            check($sformatf("warn_ramp_m%0d", m), outs(), ex(0, lv, lv >> 1, 0));
        end

        // 4. alarm blink, status=1 ignored, then ack
        edge_in(1'b1, 2'd3, 1'b0);
        check("alarm_active_on", {31'd0, alarm_active}, 32'd1);
        for (int m = 1; m <= 32; m++) begin
            if (m == 5) edge_in(1'b1, 2'd1, 1'b0);
            else step();
            check($sformatf("alarm_blink_m%0d", m), outs(),
                  ex(1, (((m - 1) / 8) % 2 != 0) ? 7 : 0, 0, 0));
        end
        edge_in(1'b0, 2'd0, 1'b1);
        check("ack_alarm_off", {31'd0, alarm_active}, 32'd0);
        step();
        check("ack_outs_zero", outs(), ex(0, 0, 0, 0));

        // 5a. ack + status=2 in alarm
        edge_in(1'b1, 2'd3, 1'b0);
        for (int m = 1; m <= 10; m++) step();
        check("alarm_bright", outs(), ex(1, 7, 0, 0));
        edge_in(1'b1, 2'd2, 1'b1);
        check("ack_warn_alarm_off", {31'd0, alarm_active}, 32'd0);
        for (int m = 1; m <= 9; m++) begin
            step();
            lv = tri_lvl((m - 1) / 4);
            check($sformatf("ack_warn_m%0d", m), outs(), ex(0, lv, lv >> 1, 0));
        end

        // 5b. ack + status=3 in alarm restarts dark
        edge_in(1'b1, 2'd3, 1'b0);
        for (int m = 1; m <= 12; m++) step();
        check("alarm2_bright", outs(), ex(1, 7, 0, 0));
        edge_in(1'b1, 2'd3, 1'b1);
        check("ack_realarm_active", {31'd0, alarm_active}, 32'd1);
        for (int m = 1; m <= 9; m++) begin
            step();
            check($sformatf("realarm_m%0d", m), outs(), ex(1, (m <= 8) ? 0 : 7, 0, 0));
        end

        // 6. reset mid-breath at level 5
        edge_in(1'b1, 2'd2, 1'b1);
        for (int m = 1; m <= 22; m++) step();
        check("breath_level5", outs(), ex(0, 5, 2, 0));
        rst = 1'b1;
        step();
        check("mid_reset_zero", outs(), ex(0, 0, 0, 0));
        rst = 1'b0;
        for (int m = 1; m <= 8; m++) begin
            step();
            check($sformatf("post_reset_off_m%0d", m), outs(), ex(0, 0, 0, 0));
        end
        edge_in(1'b0, 2'd0, 1'b1);
        step();
        check("ack_outside_alarm", outs(), ex(0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
